// File: rtl/mux_nto1_reg_pkg.sv
// rtl/mux_nto1_reg_pkg.sv - shared constants and channel-slice helper for the N:1 registered mux
//
// Purpose:
//   Select-mode constants shared by the mux top level and any other block
//   that instantiates it, plus a slice macro for flattened multi-channel buses.
//   Channel i of a flattened bus occupies bits [i*w +: w].

`ifndef MUX_NTO1_REG_PKG_SV
`define MUX_NTO1_REG_PKG_SV

// Slice channel idx (width w) out of a flattened bus.
`define MUX_CH(bus, idx, w) bus[(idx)*(w) +: (w)]

package mux_nto1_reg_pkg;

  // Grant source: explicit channel index from the sel port.
  localparam int MODE_EXPLICIT = 0;
  // Grant source: internal round-robin arbiter.
  localparam int MODE_RR       = 1;

  // Smallest and largest supported channel counts.
  localparam int NUM_IN_MIN    = 2;
  localparam int NUM_IN_MAX    = 16;

endpackage

`endif

// File: rtl/mux_nto1_reg_rr_arbiter_n.sv
// rtl/mux_nto1_reg_rr_arbiter_n.sv - combinational round-robin arbiter, one-hot and encoded grant
//
// Purpose:
//   Given NUM_IN request lines and the index of the last granted channel,
//   grant the first requester found searching ptr+1, ptr+2, ... modulo
//   NUM_IN. No state is kept here; the owner holds and updates ptr.
//
// Ports:
//   req          in   NUM_IN  request per channel
//   ptr          in   SEL_W   index of the most recently granted channel
//   grant        out  NUM_IN  one-hot grant, all-zero when no request
//   grant_idx    out  SEL_W   encoded grant index, 0 when no request
//   grant_valid  out  1       at least one request was granted

module rr_arbiter_n #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  always_comb begin
    int cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    // Walk the rotation order starting just after ptr; the inner loop maps
    // the rotated position back to a channel so every index is a loop
    // constant rather than a computed one.
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = (int'(ptr) + k) % NUM_IN;
      for (int i = 0; i < NUM_IN; i++) begin
        if (!grant_valid && (i == cand) && req[i]) begin
          grant[i]    = 1'b1;
          grant_idx   = SEL_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_nto1_reg.sv
// rtl/mux_nto1_reg.sv - N:1 W-bit mux with registered output and valid/ready on every port
//
// Purpose:
//   Selects one of NUM_IN flattened input channels, either by explicit index
//   (MODE_EXPLICIT) or by round-robin arbitration (MODE_RR), and captures it
//   into a single output register that can stall under out_ready.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst_n      in   1             asynchronous active-low reset
//   in_data    in   NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   in   NUM_IN        channel i presents data
//   in_ready   out  NUM_IN        channel i accepted this cycle (one-hot/zero)
//   sel        in   SEL_W         channel index, explicit mode only
//   out_data   out  WIDTH         registered selected data
//   out_src    out  SEL_W         channel that supplied out_data
//   out_valid  out  1             out_data/out_src valid
//   out_ready  in   1             consumer accepts output this cycle

`include "mux_nto1_reg_pkg.sv"

module mux_nto1_reg
  import mux_nto1_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = MODE_EXPLICIT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int SEL_N = 1 << SEL_W;

  // Output register and arbitration pointer.
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_src_q,   out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  // Grant produced by whichever select mode is built.
  logic [NUM_IN-1:0] grant_oh;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_valid;

  logic              load;
  logic [WIDTH-1:0]  mux_data;

  // The register may take new data when it is empty or being drained this
  // cycle; this is what allows back-to-back transfers with no bubble.
  assign load = !out_valid_q || out_ready;

  if (MODE == MODE_RR) begin : g_rr
    // sel has no meaning in this mode.
    logic unused_sel;
    assign unused_sel = ^sel;

    rr_arbiter_n #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
    ) u_arb (
      .req         (in_valid),
      .ptr         (rr_ptr_q),
      .grant       (grant_oh),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
    );
  end else begin : g_sel
    // Zero-pad the valid vector to the full sel range so an index at or
    // beyond NUM_IN simply reads as "not valid" and never grants.
    logic [SEL_N-1:0] valid_pad;

    always_comb begin
      valid_pad               = '0;
      valid_pad[NUM_IN-1:0]   = in_valid;
    end

    assign grant_idx   = sel;
    assign grant_valid = valid_pad[sel];

    always_comb begin
      grant_oh = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        grant_oh[i] = grant_valid && (sel == SEL_W'(i));
      end
    end
  end

  // Flattened-bus data mux driven by the encoded grant.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        mux_data = `MUX_CH(in_data, i, WIDTH);
      end
    end
  end

  // Handshake back to the sources: only the granted channel, and only when
  // the register can actually take it.
  assign in_ready = load ? grant_oh : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_valid) begin
        out_data_d  = mux_data;
        out_src_d   = grant_idx;
        out_valid_d = 1'b1;
        if (MODE == MODE_RR) begin
          rr_ptr_d = grant_idx;
        end
      end else begin
        // Nothing to forward: emit a bubble but keep the last data/source.
        out_valid_d = 1'b0;
      end
    end
  end

  // rr_ptr resets to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule
